aurora_crc16_inserter: RTL and testbench
========================================

// Module: aurora_crc16_inserter
// PURPOSE
//  TX-side CRC generator for the Aurora framing link. It takes AXI4-Stream frames from user logic,
//  computes the 16-bit CRC over every data word, and appends one trailer word that carries the CRC.
//  It sits between the frame source and the Aurora TX user interface. Its output is exactly what
//  the RX-side CRC checker accepts: CRC in tdata[31:16], tkeep=4'hC, tlast=1.
//  [0:31] byte-ordering convention is the same as the checker: connect [0:31] tdata straight through.
// PARAMETERS
//  CRC_POLY   16'h1021  CRC-16 generator polynomial, must match dual_crc16
//  CRC_INIT   16'hFFFF  CRC register value at start of each frame
//  DEBUG      "FALSE"   "TRUE" instantiates ILA on s/m AXIS signals and state
// PORTS
//  s_axis_aclk      in   1   single clock for all logic
//  aresetn          in   1   asynchronous, active-low reset
//  channel_up       in   1   Aurora channel status; low aborts the frame in progress
//  s_axis_tdata     in   32  frame data from user
//  s_axis_tkeep     in   4   byte enables; must be 4'hF on every input beat
//  s_axis_tuser     in   1   user sideband, forwarded with data
//  s_axis_tlast     in   1   last data word of frame
//  s_axis_tvalid    in   1   input beat valid
//  s_axis_tready    out  1   input beat accepted when tvalid&&tready
//  m_axis_tdata     out  32  data words, then the CRC trailer {crc,16'h0000}
//  m_axis_tkeep     out  4   forwarded tkeep; 4'hC on trailer
//  m_axis_tuser     out  1   forwarded tuser; 0 on trailer
//  m_axis_tlast     out  1   asserted only on trailer word
//  m_axis_tvalid    out  1   output beat valid
//  m_axis_tready    in   1   downstream (Aurora TX) ready
//  keep_err         out  1   1-cycle pulse: accepted input beat had tkeep!=4'hF
//  abort_err        out  1   1-cycle pulse: frame aborted by channel_up low mid-frame
//  frame_count      out  16  trailers sent since reset, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (aresetn low, async): state=IDLE; crc=CRC_INIT. All outputs 0, including s_axis_tready.
//   Reset released mid-frame: no partial frame is resumed.
//  Output stage: one register, latency 1. The register loads when !m_axis_tvalid || m_axis_tready.
//   m_axis_* holds stable while tvalid&&!tready (AXIS rule).
//  FSM:
//   IDLE: s_axis_tready = channel_up && output reg loadable.
//         First accepted beat -> DATA. If that beat has tlast -> CRC.
//   DATA: same tready. Every accepted beat is copied to the output reg with m_tlast=0
//         and updates the crc register. Accepted beat with s_tlast=1 -> CRC.
//   CRC:  s_axis_tready=0. When the output reg is loadable, load the trailer:
//         {crc_final,16'h0}, tkeep=4'hC, tuser=0, tlast=1. Then -> IDLE.
//         crc resets to CRC_INIT; frame_count increments.
//  CRC: crc <= f(crc, s_axis_tdata) on each accepted beat, processing 32 bits per cycle.
//   tdata[0] is the first bit shifted, matching dual_crc16. The tlast beat is included.
//   No final XOR.
//  Trailer timing: emitted the cycle after the last data word leaves the output reg,
//   or back-to-back if tready stays high. It is never dropped or duplicated under backpressure.
//  Frame length: any length >=1 word is accepted. A 1-word frame produces 2 output beats.
//  keep_err: the beat is still forwarded and included in the CRC. The RX checker flags it.
//  channel_up low in DATA or CRC:
//   state->IDLE next cycle; pulse abort_err; output tvalid cleared; crc=CRC_INIT; no trailer.
//   Remaining input beats up to and including tlast are consumed and discarded once channel_up
//   returns; this is tracked by a drop flag.
//  channel_up low in IDLE: tready=0 and no pulse.
// TESTING
//  1. 4-word frame 0x00000001..0x00000004, tready=1 -> 5 output beats;
//     beat 5 tkeep=4'hC, tlast=1, tdata[31:16]=model CRC; RX checker reports pass_fail_n=1.
//  2. 1-word frame 0xDEADBEEF -> beat1 tlast=0, beat2 trailer; frame_count 0->1.
//  3. Random m_axis_tready (50%) over 100 frames of 1-33 words -> data/trailer order intact;
//     tdata stable while stalled; frame_count=100.
//  4. Input beat tkeep=4'h7 mid-frame -> keep_err pulses 1 cycle; frame still completes with trailer.
//  5. channel_up low after word 2 of 6 -> abort_err pulse, no trailer; words 3-6 dropped;
//     next frame's CRC correct.
//  6. aresetn low during CRC state -> all outputs 0 immediately;
//     after release, first frame sent correctly.

Source files
------------

// File: rtl/aurora_crc16_inserter.sv
// TX-side CRC-16 inserter for the Aurora framing link: forwards AXI4-Stream data words and
// appends one trailer word {crc,16'h0000} with tkeep=4'hC and tlast=1.
module aurora_crc16_inserter #(
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter string       DEBUG    = "FALSE"
) (
  input  logic        s_axis_aclk,
  input  logic        aresetn,
  input  logic        channel_up,
  input  logic [31:0] s_axis_tdata,
  input  logic [3:0]  s_axis_tkeep,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        keep_err,
  output logic        abort_err,
  output logic [15:0] frame_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned CNT_W  = 16;

  localparam logic [KEEP_W-1:0] KEEP_FULL    = KEEP_W'(4'hF);
  localparam logic [KEEP_W-1:0] KEEP_TRAILER = KEEP_W'(4'hC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CRC_W-1:0]  crc;
  logic              active;
  logic              drop;
  logic              out_loadable;
  logic              tready_c;
  logic              load_data;
  logic              load_trailer;
  logic              abort;
  logic              set_drop;
  logic              discard;

  // 32 serial steps per word, tdata[0] shifted in first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (r[CRC_W-1] ^ d[i]) r = {r[CRC_W-2:0], 1'b0} ^ CRC_POLY;
      else                   r = {r[CRC_W-2:0], 1'b0};
    end
    return r;
  endfunction

  assign out_loadable  = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = tready_c;

  always_ff @(posedge s_axis_aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt    = state;
    tready_c     = 1'b0;
    load_data    = 1'b0;
    load_trailer = 1'b0;
    abort        = 1'b0;
    set_drop     = 1'b0;
    discard      = 1'b0;
    case (state)
      ST_IDLE: begin
        // While dropping the tail of an aborted frame, beats are swallowed without the output reg.
        tready_c = active && channel_up && (drop || out_loadable);
        if (s_axis_tvalid && tready_c) begin
          if (drop) begin
            discard = 1'b1;
          end else begin
            load_data = 1'b1;
            state_nxt = s_axis_tlast ? ST_CRC : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (!channel_up) begin
          abort     = 1'b1;
          set_drop  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          tready_c = out_loadable;
          if (s_axis_tvalid && out_loadable) begin
            load_data = 1'b1;
            if (s_axis_tlast) state_nxt = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (!channel_up) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (out_loadable) begin
          load_trailer = 1'b1;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output register, CRC accumulator, status flags and frame counter.
  always_ff @(posedge s_axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      active        <= 1'b0;
      drop          <= 1'b0;
      crc           <= CRC_INIT;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      keep_err      <= 1'b0;
      abort_err     <= 1'b0;
      frame_count   <= '0;
    end else begin
      active    <= 1'b1;
      keep_err  <= load_data && (s_axis_tkeep != KEEP_FULL);
      abort_err <= abort;

      if (abort || load_trailer) crc <= CRC_INIT;
      else if (load_data)        crc <= crc_step(crc, s_axis_tdata);

      if (set_drop)                     drop <= 1'b1;
      else if (discard && s_axis_tlast) drop <= 1'b0;

      if (abort) begin
        m_axis_tvalid <= 1'b0;
      end else if (load_data) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tlast  <= 1'b0;
        m_axis_tvalid <= 1'b1;
      end else if (load_trailer) begin
        m_axis_tdata  <= {crc, 16'h0000};
        m_axis_tkeep  <= KEEP_TRAILER;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (load_trailer) frame_count <= frame_count + CNT_W'(1);
    end
  end

  // Probe hook for the ILA added by the debug build.
  if (DEBUG == "TRUE") begin : g_debug
    (* mark_debug = "true" *) state_t dbg_state;
    assign dbg_state = state;
  end

endmodule

// File: tb/tb_aurora_crc16_inserter.sv
// Directed bench for aurora_crc16_inserter: frame forwarding, CRC trailer, backpressure,
// tkeep errors, channel-down abort and asynchronous reset.
module tb_aurora_crc16_inserter;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;

  logic        clk;
  logic        aresetn;
  logic        channel_up;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        keep_err;
  logic        abort_err;
  logic [15:0] frame_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit          hold_chk = 1'b1;
  int          exp_fc = 0;
  int          keep_pulses = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] cur_beat;
  logic [63:0] held;
  bit          was_stalled;

  aurora_crc16_inserter dut (
    .s_axis_aclk   (clk),
    .aresetn       (aresetn),
    .channel_up    (channel_up),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .keep_err      (keep_err),
    .abort_err     (abort_err),
    .frame_count   (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic u, input logic l, input logic [3:0] k,
                                       input logic [31:0] d);
    return {26'd0, u, l, k, d};
  endfunction

  // Reference CRC: one message bit at a time, word bit 0 first.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 32; b++) begin
      fb = r[15] ^ w[b];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  assign cur_beat = beat(m_tuser, m_tlast, m_tkeep, m_tdata);

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: captures transfers and checks the beat holds while stalled.
  always @(negedge clk) begin
    if (hold_chk && was_stalled) begin
      chk("stall_valid", 64'(m_tvalid), 64'd1);
      chk("stall_beat", cur_beat, held);
    end
    if (m_tvalid && m_tready) obs_q.push_back(cur_beat);
    if (keep_err === 1'b1) keep_pulses <= keep_pulses + 1;
    was_stalled <= m_tvalid && !m_tready;
    held        <= cur_beat;
  end

  task automatic put_beat(input logic [31:0] d, input logic [3:0] k, input logic u,
                          input logic l);
    int cyc;
    bit hs;
    cyc = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      hs = s_tready && s_tvalid;
      @(posedge clk);
      #1;
      cyc++;
    end while (!hs && cyc < 1000);
    if (!hs) chk("src_timeout", 64'(hs), 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit rnd, input logic [31:0] base,
                            input int bad_idx);
    logic [15:0] c;
    logic [31:0] d;
    logic [3:0]  k;
    logic        u;
    c = INIT;
    for (int i = 0; i < n; i++) begin
      d = rnd ? $urandom() : base + 32'(i);
      k = (i == bad_idx) ? 4'h7 : 4'hF;
      u = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      put_beat(d, k, u, i == n - 1);
      if (i == bad_idx) chk("keep_err_pulse", 64'(keep_err), 64'd1);
      exp_q.push_back(beat(u, 1'b0, k, d));
      c = crc_word(c, d);
    end
    exp_q.push_back(beat(1'b0, 1'b1, 4'hC, {c, 16'h0000}));
    exp_fc++;
  endtask

  task automatic drain(input string tag);
    int cyc;
    int n;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_m"}, {23'd0, m_tvalid, cur_beat[39:0]}, 64'd0);
    chk({tag, "_flags"}, {46'd0, keep_err, abort_err, frame_count}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1);
  end

  initial begin
    int kp0;
    aresetn    = 1'b1;
    channel_up = 1'b1;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tuser    = 1'b0;
    s_tlast    = 1'b0;
    #1 aresetn = 1'b0;
    #6;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk);
    #1;

    // 4-word frame with constant ready
    send_frame(4, 1'b0, 32'h0000_0001, -1);
    drain("t1");
    chk("t1_fc", 64'(frame_count), 64'(exp_fc));

    // single-word frame
    send_frame(1, 1'b0, 32'hDEAD_BEEF, -1);
    drain("t2");
    chk("t2_fc", 64'(frame_count), 64'(exp_fc));

    // 100 random frames under random backpressure, counted from reset
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    exp_fc = 0;
    @(posedge clk);
    #1;
    ready_mode = 1;
    for (int f = 0; f < 100; f++) send_frame($urandom_range(1, 33), 1'b1, 32'd0, -1);
    ready_mode = 0;
    drain("t3");
    chk("t3_fc", 64'(frame_count), 64'd100);

    // short-keep beat mid-frame
    kp0 = keep_pulses;
    send_frame(5, 1'b0, 32'hA000_0000, 2);
    drain("t4");
    chk("t4_keep_pulses", 64'(keep_pulses - kp0), 64'd1);
    chk("t4_fc", 64'(frame_count), 64'(exp_fc));

    // channel down after word 2 of 6
    put_beat(32'hB000_0001, 4'hF, 1'b0, 1'b0);
    exp_q.push_back(beat(1'b0, 1'b0, 4'hF, 32'hB000_0001));
    put_beat(32'hB000_0002, 4'hF, 1'b0, 1'b0);
    exp_q.push_back(beat(1'b0, 1'b0, 4'hF, 32'hB000_0002));
    channel_up = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_abort_pulse", 64'(abort_err), 64'd1);
    chk("t5_abort_tvalid", 64'(m_tvalid), 64'd0);
    s_tdata  = 32'hB000_0003;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_abort_pulse_end", 64'(abort_err), 64'd0);
    chk("t5_chdown_tready", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    channel_up = 1'b1;
    for (int i = 3; i <= 6; i++) put_beat(32'hB000_0000 + 32'(i), 4'hF, 1'b0, i == 6);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_drop_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_fc", 64'(frame_count), 64'(exp_fc));
    send_frame(3, 1'b0, 32'hC000_0000, -1);
    drain("t5");
    chk("t5_fc_after", 64'(frame_count), 64'(exp_fc));

    // async reset while the trailer is pending behind a stalled data word
    hold_chk = 1'b0;
    put_beat(32'hD000_0001, 4'hF, 1'b0, 1'b0);
    put_beat(32'hD000_0002, 4'hF, 1'b0, 1'b1);
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_stall", {62'd0, m_tvalid, m_tlast}, 64'd2);
    #2 aresetn = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    obs_q.delete();
    exp_q.delete();
    exp_fc     = 0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    hold_chk = 1'b1;
    send_frame(4, 1'b0, 32'hE000_0000, -1);
    drain("t6");
    chk("t6_fc", 64'(frame_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
